// File: rtl/alu_pkg.sv
// Shared opcode encoding, issue-FSM states and shift decode for the MIPS ALU
// and its sequencing front-end.
package alu_pkg;

    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_SUB = 4'h1;
    localparam logic [3:0] ALU_AND = 4'h2;
    localparam logic [3:0] ALU_OR  = 4'h3;
    localparam logic [3:0] ALU_SHL = 4'h4;
    localparam logic [3:0] ALU_SHR = 4'h5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } alu_issue_state_e;

    function automatic logic is_shift(input logic [3:0] op);
        return (op == ALU_SHL) || (op == ALU_SHR);
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Request/response valid-ready channels between a requester and alu_issue_ctrl.
interface alu_issue_ctrl_if #(
    parameter int ALU_SIZE = 8
);
    logic                req_valid;
    logic                req_ready;
    logic [3:0]          req_op;
    logic [ALU_SIZE-1:0] req_a;
    logic [ALU_SIZE-1:0] req_b;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [ALU_SIZE-1:0] rsp_data;
    logic                rsp_carry;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_carry
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_carry
    );
endinterface

// File: rtl/alu_unit.sv
// Combinational MIPS ALU; shifts move operand A by SHIFT_BIT and report the
// bit shifted out on carry_out.
module alu_unit
    import alu_pkg::*;
#(
    parameter int ALU_SIZE  = 8,
    parameter int SHIFT_BIT = 1
) (
    input  logic [ALU_SIZE-1:0] alu_in_a,
    input  logic [ALU_SIZE-1:0] alu_in_b,
    input  logic [3:0]          alu_sel,
    output logic [ALU_SIZE-1:0] alu_out,
    output logic                carry_out
);
    logic [ALU_SIZE:0] wide_s;

    // Opcode decode; SUB reports borrow on carry_out
    always_comb begin
        wide_s    = {(ALU_SIZE+1){1'b0}};
        alu_out   = {ALU_SIZE{1'b0}};
        carry_out = 1'b0;
        case (alu_sel)
            ALU_ADD: begin
                wide_s    = {1'b0, alu_in_a} + {1'b0, alu_in_b};
                alu_out   = wide_s[ALU_SIZE-1:0];
                carry_out = wide_s[ALU_SIZE];
            end
            ALU_SUB: begin
                wide_s    = {1'b0, alu_in_a} - {1'b0, alu_in_b};
                alu_out   = wide_s[ALU_SIZE-1:0];
                carry_out = wide_s[ALU_SIZE];
            end
            ALU_AND: alu_out = alu_in_a & alu_in_b;
            ALU_OR:  alu_out = alu_in_a | alu_in_b;
            ALU_SHL: begin
                alu_out   = alu_in_a << SHIFT_BIT;
                carry_out = alu_in_a[ALU_SIZE-SHIFT_BIT];
            end
            ALU_SHR: begin
                alu_out   = alu_in_a >> SHIFT_BIT;
                carry_out = alu_in_a[SHIFT_BIT-1];
            end
            default: begin
                alu_out   = {ALU_SIZE{1'b0}};
                carry_out = 1'b0;
            end
        endcase
    end
endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/sequencing front-end for alu_unit. Define ALU_ISSUE_SHIFT_ITER_EN to run
// multi-bit shifts as repeated 1-bit ALU passes; otherwise shifts take one pass.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int ALU_SIZE = 8,
    parameter int SHAMT_W  = $clog2(ALU_SIZE)
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_issue_ctrl_if.slave     bus,
    output logic [ALU_SIZE-1:0] alu_in_a,
    output logic [ALU_SIZE-1:0] alu_in_b,
    output logic [3:0]          alu_sel,
    input  logic [ALU_SIZE-1:0] alu_out,
    input  logic                carry_out
);
`ifdef ALU_ISSUE_SHIFT_ITER_EN
    localparam int CNT_W = SHAMT_W;
`else
    // every op is one pass, so a single count bit suffices for any amount width
    localparam int CNT_W = (SHAMT_W > 0) ? 1 : 1;
`endif

    alu_issue_state_e    state_r, state_s;
    logic [CNT_W-1:0]    cnt_r, cnt_s;
    logic [ALU_SIZE-1:0] a_r, a_s, b_r, b_s, data_r, data_s;
    logic [3:0]          sel_r, sel_s;
    logic                carry_r, carry_s, valid_r, valid_s;
`ifdef ALU_ISSUE_SHIFT_ITER_EN
    logic [SHAMT_W-1:0]  shamt_s;
    assign shamt_s = bus.req_b[SHAMT_W-1:0];
`endif

    // Next-state and datapath-register decode
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        a_s     = a_r;
        b_s     = b_r;
        sel_s   = sel_r;
        data_s  = data_r;
        carry_s = carry_r;
        case (state_r)
            IDLE: begin
                if (bus.req_valid) begin
                    a_s   = bus.req_a;
                    sel_s = bus.req_op;
                    if (is_shift(bus.req_op)) begin
                        b_s = {ALU_SIZE{1'b0}};
`ifdef ALU_ISSUE_SHIFT_ITER_EN
                        if (shamt_s == {SHAMT_W{1'b0}}) begin
                            state_s = DONE;
                            data_s  = bus.req_a;
                            carry_s = 1'b0;
                        end else begin
                            state_s = EXEC;
                            cnt_s   = shamt_s;
                        end
`else
                        state_s = EXEC;
                        cnt_s   = CNT_W'(1);
`endif
                    end else begin
                        b_s     = bus.req_b;
                        state_s = EXEC;
                        cnt_s   = CNT_W'(1);
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            EXEC: begin
                data_s  = alu_out;
                carry_s = carry_out;
                if (cnt_r == CNT_W'(1)) begin
                    state_s = DONE;
                end else begin
                    a_s   = alu_out;
                    cnt_s = cnt_r - CNT_W'(1);
                end
            end
            DONE: begin
                if (bus.rsp_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    assign valid_s = (state_s == DONE);

    // State, counter and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            a_r     <= {ALU_SIZE{1'b0}};
            b_r     <= {ALU_SIZE{1'b0}};
            sel_r   <= 4'h0;
            data_r  <= {ALU_SIZE{1'b0}};
            carry_r <= 1'b0;
            valid_r <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            a_r     <= a_s;
            b_r     <= b_s;
            sel_r   <= sel_s;
            data_r  <= data_s;
            carry_r <= carry_s;
            valid_r <= valid_s;
        end
    end

    assign bus.req_ready = (state_r == IDLE);
    assign bus.rsp_valid = valid_r;
    assign bus.rsp_data  = data_r;
    assign bus.rsp_carry = carry_r;
    assign alu_in_a      = a_r;
    assign alu_in_b      = b_r;
    assign alu_sel       = sel_r;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl driving a real alu_unit; expectations follow
// the ALU_ISSUE_SHIFT_ITER_EN setting of the build.
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [7:0] alu_in_a, alu_in_b, alu_out;
    logic [3:0] alu_sel;
    logic       carry_out;
    int         checks   = 0;
    int         failures = 0;

    alu_issue_ctrl_if #(.ALU_SIZE(8)) ifc ();

    alu_issue_ctrl #(.ALU_SIZE(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (ifc.slave),
        .alu_in_a  (alu_in_a),
        .alu_in_b  (alu_in_b),
        .alu_sel   (alu_sel),
        .alu_out   (alu_out),
        .carry_out (carry_out)
    );

    alu_unit #(.ALU_SIZE(8), .SHIFT_BIT(1)) u_alu (
        .alu_in_a  (alu_in_a),
        .alu_in_b  (alu_in_b),
        .alu_sel   (alu_sel),
        .alu_out   (alu_out),
        .carry_out (carry_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one request for a single accept edge, then withdraw it
    task automatic do_req(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        ifc.req_valid = 1'b1;
        ifc.req_op    = op;
        ifc.req_a     = a;
        ifc.req_b     = b;
        tick();
        ifc.req_valid = 1'b0;
    endtask

    task automatic finish_rsp(input string tag);
        ifc.rsp_ready = 1'b1;
        tick();
        ifc.rsp_ready = 1'b0;
        chk({tag, "_hs_valid"}, 32'(ifc.rsp_valid), 32'h0);
        chk({tag, "_hs_ready"}, 32'(ifc.req_ready), 32'h1);
    endtask

    initial begin
        rst_n         = 1'b0;
        ifc.req_valid = 1'b0;
        ifc.req_op    = 4'h0;
        ifc.req_a     = 8'h00;
        ifc.req_b     = 8'h00;
        ifc.rsp_ready = 1'b0;
        tick();
        tick();
        chk("rst_valid", 32'(ifc.rsp_valid), 32'h0);
        chk("rst_data",  32'(ifc.rsp_data),  32'h0);
        chk("rst_carry", 32'(ifc.rsp_carry), 32'h0);
        chk("rst_in_a",  32'(alu_in_a),      32'h0);
        chk("rst_in_b",  32'(alu_in_b),      32'h0);
        chk("rst_sel",   32'(alu_sel),       32'h0);
        chk("rst_ready", 32'(ifc.req_ready), 32'h1);
        rst_n = 1'b1;
        tick();

        // ADD 0x0A + 0x02
        do_req(ALU_ADD, 8'h0A, 8'h02);
        chk("add1_exec_valid", 32'(ifc.rsp_valid), 32'h0);
        chk("add1_in_a",  32'(alu_in_a), 32'h0A);
        chk("add1_in_b",  32'(alu_in_b), 32'h02);
        chk("add1_ready", 32'(ifc.req_ready), 32'h0);
        tick();
        chk("add1_valid", 32'(ifc.rsp_valid), 32'h1);
        chk("add1_data",  32'(ifc.rsp_data),  32'h0C);
        chk("add1_carry", 32'(ifc.rsp_carry), 32'h0);
        finish_rsp("add1");

        // ADD wrap with carry
        do_req(ALU_ADD, 8'hF6, 8'h0A);
        tick();
        chk("add2_valid", 32'(ifc.rsp_valid), 32'h1);
        chk("add2_data",  32'(ifc.rsp_data),  32'h00);
        chk("add2_carry", 32'(ifc.rsp_carry), 32'h1);
        finish_rsp("add2");

        // SHL 0x0A by 3
        do_req(ALU_SHL, 8'h0A, 8'h03);
        chk("shl3_in_a0", 32'(alu_in_a), 32'h0A);
        chk("shl3_in_b",  32'(alu_in_b), 32'h00);
`ifdef ALU_ISSUE_SHIFT_ITER_EN
        chk("shl3_v0", 32'(ifc.rsp_valid), 32'h0);
        tick();
        chk("shl3_in_a1", 32'(alu_in_a), 32'h14);
        chk("shl3_v1", 32'(ifc.rsp_valid), 32'h0);
        tick();
        chk("shl3_in_a2", 32'(alu_in_a), 32'h28);
        chk("shl3_v2", 32'(ifc.rsp_valid), 32'h0);
        tick();
        chk("shl3_valid", 32'(ifc.rsp_valid), 32'h1);
        chk("shl3_data",  32'(ifc.rsp_data),  32'h50);
`else
        tick();
        chk("shl3_valid", 32'(ifc.rsp_valid), 32'h1);
        chk("shl3_data",  32'(ifc.rsp_data),  32'h14);
`endif
        chk("shl3_carry", 32'(ifc.rsp_carry), 32'h0);
        finish_rsp("shl3");

        // SHR 0x81 by 1
        do_req(ALU_SHR, 8'h81, 8'h01);
        tick();
        chk("shr1_valid", 32'(ifc.rsp_valid), 32'h1);
        chk("shr1_data",  32'(ifc.rsp_data),  32'h40);
        chk("shr1_carry", 32'(ifc.rsp_carry), 32'h1);
        finish_rsp("shr1");

        // SHL by 0
        do_req(ALU_SHL, 8'h5A, 8'h00);
`ifdef ALU_ISSUE_SHIFT_ITER_EN
        chk("shl0_valid", 32'(ifc.rsp_valid), 32'h1);
        chk("shl0_data",  32'(ifc.rsp_data),  32'h5A);
`else
        chk("shl0_exec_valid", 32'(ifc.rsp_valid), 32'h0);
        tick();
        chk("shl0_valid", 32'(ifc.rsp_valid), 32'h1);
        chk("shl0_data",  32'(ifc.rsp_data),  32'hB4);
`endif
        chk("shl0_carry", 32'(ifc.rsp_carry), 32'h0);
        finish_rsp("shl0");

        // Backpressure with a second request waiting
        do_req(ALU_AND, 8'hF0, 8'h3C);
        tick();
        ifc.req_valid = 1'b1;
        ifc.req_op    = ALU_OR;
        ifc.req_a     = 8'h0F;
        ifc.req_b     = 8'h50;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", 32'(ifc.rsp_valid), 32'h1);
            chk("bp_data",  32'(ifc.rsp_data),  32'h30);
            chk("bp_ready", 32'(ifc.req_ready), 32'h0);
        end
        ifc.rsp_ready = 1'b1;
        tick();
        ifc.rsp_ready = 1'b0;
        chk("bp_hs_valid", 32'(ifc.rsp_valid), 32'h0);
        chk("bp_hs_ready", 32'(ifc.req_ready), 32'h1);
        chk("bp_no_accept_sel", 32'(alu_sel), 32'(ALU_AND));
        tick();
        ifc.req_valid = 1'b0;
        chk("bp2_sel",   32'(alu_sel),  32'(ALU_OR));
        chk("bp2_in_a",  32'(alu_in_a), 32'h0F);
        chk("bp2_ready", 32'(ifc.req_ready), 32'h0);
        tick();
        chk("bp2_valid", 32'(ifc.rsp_valid), 32'h1);
        chk("bp2_data",  32'(ifc.rsp_data),  32'h5F);
        finish_rsp("bp2");

        // Asynchronous reset inside a k=5 shift
        do_req(ALU_SHL, 8'h01, 8'h05);
`ifdef ALU_ISSUE_SHIFT_ITER_EN
        tick();
        chk("rmid_in_a", 32'(alu_in_a), 32'h02);
`endif
        #2;
        rst_n = 1'b0;
        #1;
        chk("rmid_valid", 32'(ifc.rsp_valid), 32'h0);
        chk("rmid_data",  32'(ifc.rsp_data),  32'h0);
        chk("rmid_carry", 32'(ifc.rsp_carry), 32'h0);
        chk("rmid_in_a",  32'(alu_in_a),      32'h0);
        chk("rmid_sel",   32'(alu_sel),       32'h0);
        tick();
        rst_n = 1'b1;
        chk("rmid_ready", 32'(ifc.req_ready), 32'h1);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("rmid_no_rsp", 32'(ifc.rsp_valid), 32'h0);
        end

        // Recovery after reset
        do_req(ALU_SUB, 8'h05, 8'h03);
        tick();
        chk("sub_valid", 32'(ifc.rsp_valid), 32'h1);
        chk("sub_data",  32'(ifc.rsp_data),  32'h02);
        chk("sub_carry", 32'(ifc.rsp_carry), 32'h0);
        finish_rsp("sub");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Sequencing front-end that owns the operand/select side of `alu_unit` in the MIPS datapath. It accepts ALU requests over a valid/ready handshake and drives `alu_in_a`, `alu_in_b` and `alu_sel` from registers. It captures `alu_out`/`carry_out` and returns the result over a second valid/ready handshake. Multi-bit shifts run as repeated passes through the 1-bit-shift ALU (`SHIFT_BIT = 1`).

## Interface
- `ALU_SIZE`, 8, datapath width; must match the attached `alu_unit`.
- `SHAMT_W`, `$clog2(ALU_SIZE)`, width of the shift-amount field taken from `req_b`.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request.
- `req_op`  in  4  ALU opcode (`alu_pkg` encoding).
- `req_a`  in  ALU_SIZE  operand A.
- `req_b`  in  ALU_SIZE  operand B; for shifts, `req_b[SHAMT_W-1:0]` is the amount.
- `rsp_valid`  out  1  result present.
- `rsp_ready`  in  1  consumer takes the result.
- `rsp_data`  out  ALU_SIZE  result.
- `rsp_carry`  out  1  carry/shifted-out bit of the final ALU pass.
- `alu_in_a`  out  ALU_SIZE  to `alu_unit.alu_in_a`.
- `alu_in_b`  out  ALU_SIZE  to `alu_unit.alu_in_b`.
- `alu_sel`  out  4  to `alu_unit.alu_sel`.
- `alu_out`  in  ALU_SIZE  from `alu_unit`, combinational.
- `carry_out`  in  1  from `alu_unit`, combinational.

## Operation
- The state machine has three states: `IDLE`, `EXEC`, `DONE`.
- **Reset.** State is `IDLE`. `rsp_valid`, `rsp_data`, `rsp_carry`, `alu_in_a`, `alu_in_b` and `alu_sel` are 0. The shift counter is 0.
- **`req_ready`** is 1 only in `IDLE`. It is decoded from the state register, with no combinational path from `rsp_ready`.
- **Accept.** A request is accepted on a clock edge where `IDLE` && `req_valid` holds.
  - On that edge, load `alu_in_a <= req_a`, `alu_in_b <= req_b` and `alu_sel <= req_op`.
  - Non-shift op: next state is `EXEC` with count 1.
  - Shift op with amount k > 0: next state is `EXEC` with count k. During shifts, `alu_in_b` is loaded with 0.
  - Shift op with k = 0: go directly to `DONE` with `rsp_data <= req_a` and `rsp_carry <= 0`.
- **`EXEC`.** Each cycle, the ALU evaluates combinationally on the registered inputs. At the edge:
  - `rsp_data <= alu_out` and `rsp_carry <= carry_out`.
  - If count = 1, go to `DONE`. Otherwise set `alu_in_a <= alu_out` and decrement the count.
  - `alu_sel` is held constant for the whole operation.
- **`DONE`.** `rsp_valid` = 1. `rsp_data` and `rsp_carry` are held stable until `rsp_valid && rsp_ready`, then the block returns to `IDLE`. No request is accepted in the same cycle as the response handshake.
- **Held ALU inputs.** `alu_in_*` and `alu_sel` keep their last values in `DONE`/`IDLE`; they are not cleared.
- **Arithmetic rules.** All arithmetic is modulo 2^ALU_SIZE; carry comes solely from `alu_unit`. Opcodes not in `alu_pkg` are passed through as single-pass ops.
- **Reset mid-operation.** Asynchronous reset abandons the in-flight op. All outputs return to reset values immediately and no response is produced.

## Timing
- Accept at edge t. A non-shift op asserts `rsp_valid` from edge t+1.
- A shift of k ≥ 1 asserts `rsp_valid` from edge t+k. A shift of k = 0 asserts `rsp_valid` from edge t, in the cycle immediately after acceptance.
- Minimum request-to-request spacing:
  - non-shift: 3 cycles (accept, `EXEC`, `DONE` with `rsp_ready`=1);
  - shift by k ≥ 1: k+2 cycles;
  - shift by 0: 2 cycles.
- All outputs are registered except `req_ready`, which is a state decode.

## Configuration
- `ALU_ISSUE_SHIFT_ITER_EN` defined:
  - Shift ops iterate `req_b[SHAMT_W-1:0]` times as described above.
- `ALU_ISSUE_SHIFT_ITER_EN` undefined:
  - Shift ops are treated as single-pass ops: count is always 1 and the result is a 1-bit shift.
  - The amount-0 bypass is removed.
  - The counter collapses to a single bit.

## Structure
- Package `alu_pkg` holds:
  - the opcode constants `ALU_ADD=4'h0`, `ALU_SUB=4'h1`, `ALU_AND=4'h2`, `ALU_OR=4'h3`, `ALU_SHL=4'h4`, `ALU_SHR=4'h5`, shared with `alu_unit`;
  - the state enum `alu_issue_state_e`;
  - the function `is_shift(op)`.
- No sub-module. The block is one FSM plus counter and registers.
- The bench instantiates `alu_unit` (`SHIFT_BIT=1`) as the real load.

## Test plan
- ADD `req_a`=0x0A, `req_b`=0x02 -> `rsp_data`=0x0C, `rsp_carry`=0, `rsp_valid` one edge after accept.
- ADD 0xF6 + 0x0A -> `rsp_data`=0x00, `rsp_carry`=1.
- SHL 0x0A by k=3 -> three `EXEC` cycles with `alu_in_a` sequence 0x0A, 0x14, 0x28; `rsp_data`=0x50, `rsp_carry`=0. SHR 0x81 by 1 -> 0x40, `rsp_carry`=1.
- SHL by k=0 with `req_a`=0x5A -> `rsp_data`=0x5A, `rsp_carry`=0, `rsp_valid` in the cycle after accept. With the macro undefined -> 0xB4 after one pass.
- Backpressure: hold `rsp_ready`=0 for 5 cycles with `req_valid`=1 and a second op waiting -> `rsp_data` stable, `req_ready`=0 throughout. The second op is accepted only after the response handshake.
- Assert `rst_n`=0 during the second `EXEC` cycle of a k=5 shift -> all outputs 0 asynchronously, `req_ready`=1 after release, no spurious `rsp_valid`.
